// File: rtl/water_flow_monitor.sv
// Drum water-flow supervisor: 4-tap level smoothing plus a windowed
// progress check that raises a sticky fault when fill/drain stalls.
module water_flow_monitor #(
  parameter int WINDOW_CYCLES = 50,
  parameter int MIN_DELTA     = 10,
  parameter int MAX_STALLS    = 3,
  parameter int FULL_LEVEL    = 1000,
  parameter int EMPTY_LEVEL   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_flow_reset,
  input  logic       water_flow_mode,
  input  logic [9:0] water_level_sensor,
  output logic [9:0] water_level,
  output logic       water_flow_error
);

  // state      | meaning
  // ST_IDLE    | held by water_flow_reset, counters cleared
  // ST_PRIME   | 4 clocks for the filter to fill with fresh samples
  // ST_MONITOR | windowed progress evaluation
  // ST_ERROR   | sticky fault until water_flow_reset
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_MONITOR = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [9:0]        WIN_LAST = 10'(WINDOW_CYCLES - 1);
  localparam logic signed [10:0] MIN_D   = 11'(MIN_DELTA);
  localparam logic [3:0]        MAX_S    = 4'(MAX_STALLS);
  localparam logic [9:0]        FULL_L   = 10'(FULL_LEVEL);
  localparam logic [9:0]        EMPTY_L  = 10'(EMPTY_LEVEL);

  state_t             state_q, state_d;
  logic [3:0][9:0]    taps_q;
  logic [11:0]        sum;
  logic [1:0]         prime_q, prime_d;
  logic [9:0]         win_q, win_d;
  logic [3:0]         stall_q, stall_d;
  logic [3:0]         stall_inc;
  logic [9:0]         start_q, start_d;
  logic               mode_q;
  logic               error_q;
  logic               mode_change;
  logic signed [10:0] diff_up, diff_dn;
  logic               progress;

  // Filter runs in every state and is cleared only by the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_q <= '0;
    end else begin
      taps_q <= {taps_q[2:0], water_level_sensor};
    end
  end

  assign sum = {2'b00, taps_q[0]} + {2'b00, taps_q[1]}
             + {2'b00, taps_q[2]} + {2'b00, taps_q[3]};
  assign water_level = sum[11:2];

  assign mode_change = (water_flow_mode != mode_q);
  assign diff_up     = $signed({1'b0, water_level}) - $signed({1'b0, start_q});
  assign diff_dn     = $signed({1'b0, start_q}) - $signed({1'b0, water_level});
  assign progress    = water_flow_mode ? ((diff_up >= MIN_D) || (water_level >= FULL_L))
                                       : ((diff_dn >= MIN_D) || (water_level <= EMPTY_L));
  assign stall_inc   = stall_q + 4'd1;

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    win_d   = win_q;
    stall_d = stall_q;
    start_d = start_q;
    if (water_flow_reset) begin
      state_d = ST_IDLE;
      prime_d = '0;
      win_d   = '0;
      stall_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          prime_d = '0;
          win_d   = '0;
          stall_d = '0;
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          if (prime_q == 2'd3) begin
            start_d = water_level;
            win_d   = '0;
            state_d = ST_MONITOR;
          end else begin
            prime_d = prime_q + 2'd1;
          end
        end
        ST_MONITOR: begin
          if (mode_change) begin
            state_d = ST_PRIME;
            prime_d = '0;
            win_d   = '0;
            stall_d = '0;
          end else if (win_q == WIN_LAST) begin
            start_d = water_level;
            win_d   = '0;
            if (progress) begin
              stall_d = '0;
            end else begin
              stall_d = stall_inc;
              if (stall_inc >= MAX_S) state_d = ST_ERROR;
            end
          end else begin
            win_d = win_q + 10'd1;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Error is registered from the next state so it rises on the failing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prime_q <= '0;
      win_q   <= '0;
      stall_q <= '0;
      start_q <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      win_q   <= win_d;
      stall_q <= stall_d;
      start_q <= start_d;
      mode_q  <= water_flow_mode;
      error_q <= (state_d == ST_ERROR);
    end
  end

  assign water_flow_error = error_q;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Self-checking bench for water_flow_monitor: timestamp-based reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_water_flow_monitor;
  localparam int W     = 8;
  localparam int MS    = 2;
  localparam int MIN_D = 10;
  localparam int FULL  = 1000;
  localparam int EMPTY = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wfr = 1'b1;
  logic       mode = 1'b1;
  logic [9:0] sensor = '0;
  logic [9:0] level;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  water_flow_monitor #(
    .WINDOW_CYCLES(W),
    .MIN_DELTA(MIN_D),
    .MAX_STALLS(MS),
    .FULL_LEVEL(FULL),
    .EMPTY_LEVEL(EMPTY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .water_flow_reset(wfr),
    .water_flow_mode(mode),
    .water_level_sensor(sensor),
    .water_level(level),
    .water_flow_error(err)
  );

  // Reference model: sample history plus edge timestamps for prime end and window start.
  int h[4] = '{0, 0, 0, 0};
  int ph = 0;           // 0 idle, 1 priming, 2 monitoring, 3 faulted
  int n = 0;
  int prime_end = 0;
  int t0 = 0;
  int st = 0;
  int stalls = 0;
  bit mprev = 1'b0;
  bit m_err = 1'b0;

  function automatic int m_level();
    return (h[0] + h[1] + h[2] + h[3]) / 4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h = '{0, 0, 0, 0};
      ph = 0; n = 0; stalls = 0; st = 0; mprev = 1'b0; m_err = 1'b0;
    end else begin
      int lvl;
      bit ok;
      n++;
      lvl = m_level();
      if (wfr) begin
        ph = 0;
        m_err = 1'b0;
      end else begin
        case (ph)
          0: begin ph = 1; prime_end = n + 4; stalls = 0; end
          1: if (n == prime_end) begin st = lvl; t0 = n; ph = 2; end
          2: begin
            if (mode != mprev) begin
              ph = 1; prime_end = n + 4; stalls = 0;
            end else if ((n - t0) % W == 0) begin
              ok = mode ? ((lvl - st >= MIN_D) || (lvl >= FULL))
                        : ((st - lvl >= MIN_D) || (lvl <= EMPTY));
              stalls = ok ? 0 : stalls + 1;
              st = lvl;
              if (stalls >= MS) begin ph = 3; m_err = 1'b1; end
            end
          end
          default: ;
        endcase
      end
      mprev = mode;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = int'(sensor);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("level_vs_model", int'(level), m_level());
    chk("error_vs_model", int'(err), int'(m_err));
  end

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Hold re-arm with a settled filter, then release; edges are counted from here.
  task automatic settle(input bit m, input int s);
    wfr = 1'b1; mode = m; sensor = 10'(s);
    step(6);
  endtask

  int s;
  int trend;
  int seg;

  initial begin
    // Reset
    sensor = 10'd300;
    step(2);
    chk("reset_level", int'(level), 0);
    chk("reset_error", int'(err), 0);
    reset = 1'b0;
    step(3);
    chk("reset_level_3clk", int'(level), 225);
    step(1);
    chk("reset_level_4clk", int'(level), 300);
    chk("model_level_4clk", m_level(), 300);

    // Good fill: ramp +2 per clock
    settle(1'b1, 100);
    wfr = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      sensor = 10'(100 + 2 * k);
      step(1);
      chk("good_fill_error", int'(err), 0);
    end

    // Stalled fill: error exactly at edge 1+4+16
    settle(1'b1, 110);
    wfr = 1'b0;
    step(20);
    chk("stall_fill_edge20", int'(err), 0);
    step(1);
    chk("stall_fill_edge21", int'(err), 1);
    chk("model_stall_edge21", int'(m_err), 1);
    step(3);
    chk("stall_fill_sticky", int'(err), 1);
    wfr = 1'b1;
    step(1);
    chk("stall_fill_rearm", int'(err), 0);

    // Drain to empty, then hold at empty
    settle(1'b0, 80);
    wfr = 1'b0;
    step(6);
    sensor = 10'd0;
    step(40);
    chk("drain_empty_error", int'(err), 0);
    chk("drain_empty_level", int'(level), 0);

    // Level rising during drain
    settle(1'b0, 0);
    wfr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sensor = 10'((10 * k > 200) ? 200 : 10 * k);
      step(1);
    end
    chk("drain_rise_edge20", int'(err), 0);
    step(1);
    chk("drain_rise_edge21", int'(err), 1);

    // Mode flip after first failing window: two fresh windows needed
    settle(1'b1, 110);
    wfr = 1'b0;
    step(13);
    mode = 1'b0;
    step(20);
    chk("flip_edge33", int'(err), 0);
    step(1);
    chk("flip_edge34", int'(err), 1);
    chk("model_flip_edge34", int'(m_err), 1);

    // Re-arm on the same edge as the error-raising evaluation
    settle(1'b1, 110);
    wfr = 1'b0;
    step(20);
    wfr = 1'b1;
    step(1);
    chk("precedence_error", int'(err), 0);
    chk("model_precedence", int'(m_err), 0);
    step(2);
    chk("precedence_idle", int'(err), 0);
    wfr = 1'b0;
    step(20);
    chk("precedence_rearm20", int'(err), 0);
    step(1);
    chk("precedence_rearm21", int'(err), 1);

    // Randomized traffic with occasional re-arm, mode flips and async reset
    wfr = 1'b0;
    s = 500;
    trend = 0;
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        seg = $urandom_range(10, 60);
        trend = $urandom_range(0, 3);
        if (trend == 0) mode = 1'b1;
        else if (trend == 1) mode = 1'b0;
      end
      seg--;
      case (trend)
        0: s = s + 3;
        1: s = s - 3;
        2: s = s;
        default: s = s + $urandom_range(0, 2) - 1;
      endcase
      if (s < 0) s = 0;
      if (s > 1023) s = 1023;
      sensor = 10'(s);
      if ($urandom_range(0, 79) == 0) mode = ~mode;
      if (wfr) wfr = ($urandom_range(0, 2) != 0);
      else wfr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
